// File: rtl/inst_inject_chk_if.sv
// Bus between the instruction injector/checker and its host: table load,
// run control, decode-uop feedback and result reporting.
interface inst_inject_chk_if #(
    parameter int INST_W = 16,
    parameter int UOP_W  = 26,
    parameter int AW     = 4
);
    logic              tbl_we;
    logic [AW-1:0]     tbl_addr;
    logic [INST_W-1:0] tbl_inst;
    logic [UOP_W-1:0]  tbl_mask;
    logic [UOP_W-1:0]  tbl_exp;
    logic              start;
    logic [AW:0]       vec_cnt;
    logic              stop_on_err;
    logic [UOP_W-1:0]  uop_in;
    logic [INST_W-1:0] inst_out;
    logic              inst_vld;
    logic              busy;
    logic              done;
    logic [AW:0]       pass_cnt;
    logic [AW:0]       err_cnt;
    logic              fail_vld;
    logic [AW-1:0]     fail_idx;

    modport master (
        output tbl_we, tbl_addr, tbl_inst, tbl_mask, tbl_exp,
        output start, vec_cnt, stop_on_err, uop_in,
        input  inst_out, inst_vld, busy, done,
        input  pass_cnt, err_cnt, fail_vld, fail_idx
    );

    modport slave (
        input  tbl_we, tbl_addr, tbl_inst, tbl_mask, tbl_exp,
        input  start, vec_cnt, stop_on_err, uop_in,
        output inst_out, inst_vld, busy, done,
        output pass_cnt, err_cnt, fail_vld, fail_idx
    );
endinterface

// File: rtl/inst_inject_chk.sv
// Replays a table of instructions into a decoder and compares the masked
// decode micro-op against expected bits, counting passes and mismatches.
module inst_inject_chk #(
    parameter int              INST_W    = 16,
    parameter int              UOP_W     = 26,
    parameter int              DEPTH     = 16,
    parameter int              LATENCY   = 1,
    parameter logic [INST_W-1:0] IDLE_INST = 16'h0800
) (
    input logic               clk,
    input logic               rst,
    inst_inject_chk_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

    logic [INST_W-1:0] r_tblInst [DEPTH];
    logic [UOP_W-1:0]  r_tblMask [DEPTH];
    logic [UOP_W-1:0]  r_tblExp  [DEPTH];

    state_t          r_state;
    state_t          w_nextState;
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_cnt;
    logic            r_stopOnErr;
    logic [WCW-1:0]  r_waitCnt;
    logic [AW:0]     r_passCnt;
    logic [AW:0]     r_errCnt;
    logic            r_failVld;
    logic [AW-1:0]   r_failIdx;

    logic            w_busy;
    logic            w_startOk;
    logic            w_mismatch;
    logic            w_last;

    assign w_busy     = (r_state == ISSUE) || (r_state == WAIT) || (r_state == CHECK);
    assign w_startOk  = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch = |((bus.uop_in ^ r_tblExp[r_idx]) & r_tblMask[r_idx]);
    assign w_last     = ({1'b0, r_idx} == (r_cnt - (AW+1)'(1)));

    // Table is deliberately outside reset so a loaded vector set survives rst.
    always_ff @(posedge clk) begin
        if (rst && bus.tbl_we && !w_busy) begin
            r_tblInst[bus.tbl_addr] <= bus.tbl_inst;
            r_tblMask[bus.tbl_addr] <= bus.tbl_mask;
            r_tblExp[bus.tbl_addr]  <= bus.tbl_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState  = r_state;
        bus.inst_out = IDLE_INST;
        bus.inst_vld = 1'b0;
        bus.busy     = w_busy;
        bus.done     = (r_state == DONE);
        if (w_busy) bus.inst_out = r_tblInst[r_idx];
        case (r_state)
            IDLE, DONE: begin
                if (w_startOk) w_nextState = (bus.vec_cnt == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                bus.inst_vld = 1'b1;
                w_nextState  = (LATENCY == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                if (r_waitCnt == WAIT_LAST) w_nextState = CHECK;
            end
            CHECK: begin
                if ((w_mismatch && r_stopOnErr) || w_last) w_nextState = DONE;
                else                                       w_nextState = ISSUE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Run bookkeeping; idx only advances when another entry will be issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_stopOnErr <= 1'b0;
            r_waitCnt   <= '0;
            r_passCnt   <= '0;
            r_errCnt    <= '0;
            r_failVld   <= 1'b0;
            r_failIdx   <= '0;
        end else begin
            if (w_startOk) begin
                r_idx       <= '0;
                r_cnt       <= (bus.vec_cnt > DEPTH_CNT) ? DEPTH_CNT : bus.vec_cnt;
                r_stopOnErr <= bus.stop_on_err;
                r_passCnt   <= '0;
                r_errCnt    <= '0;
                r_failVld   <= 1'b0;
                r_failIdx   <= '0;
            end
            if (r_state == ISSUE) r_waitCnt <= '0;
            if (r_state == WAIT)  r_waitCnt <= r_waitCnt + WCW'(1);
            if (r_state == CHECK) begin
                if (w_mismatch) begin
                    r_errCnt <= r_errCnt + (AW+1)'(1);
                    if (!r_failVld) begin
                        r_failVld <= 1'b1;
                        r_failIdx <= r_idx;
                    end
                end else begin
                    r_passCnt <= r_passCnt + (AW+1)'(1);
                end
                if (w_nextState == ISSUE) r_idx <= r_idx + AW'(1);
            end
        end
    end

    assign bus.pass_cnt = r_passCnt;
    assign bus.err_cnt  = r_errCnt;
    assign bus.fail_vld = r_failVld;
    assign bus.fail_idx = r_failIdx;
endmodule

// File: doc/inst_inject_chk.md
INST_INJECT_CHK -- requirements
Module: inst_inject_chk

Interface
REQ-001: Parameter INST_W, 16, instruction width.
REQ-002: Parameter UOP_W, 26, width of the decode micro-op vector under check.
REQ-003: Parameter DEPTH, 16, vector-table entries (power of 2, >=2); index width AW = log2(DEPTH).
REQ-004: Parameter LATENCY, 1, cycles from instruction issue to uop sample (>=1).
REQ-005: Parameter IDLE_INST, 16'h0800 (NOP), instruction driven when not issuing.
REQ-006: clk  in  1  single clock, all state on rising edge.
REQ-007: rst  in  1  synchronous, active-low reset.
REQ-008: tbl_we  in  1  table write strobe.
REQ-009: tbl_addr  in  AW  table write index.
REQ-010: tbl_inst / tbl_mask / tbl_exp  in  INST_W / UOP_W / UOP_W  instruction, compare mask, expected uop bits.
REQ-011: start  in  1  one-cycle run request.
REQ-012: vec_cnt  in  AW+1  number of entries to run (0..DEPTH), sampled on accepted start.
REQ-013: stop_on_err  in  1  halt on first mismatch, sampled on accepted start.
REQ-014: uop_in  in  UOP_W  decode uop vector from the DUT.
REQ-015: inst_out  out  INST_W  instruction to the DUT fetch/decode input.
REQ-016: inst_vld  out  1  high only in the issue cycle of each entry.
REQ-017: busy / done  out  1 / 1  run in progress / run finished.
REQ-018: pass_cnt / err_cnt  out  AW+1 / AW+1  checked-good and mismatched entry counts.
REQ-019: fail_vld / fail_idx  out  1 / AW  first mismatch captured, and its table index.

Function
REQ-020: FSM states IDLE, ISSUE, WAIT, CHECK, DONE; busy = state in {ISSUE, WAIT, CHECK}.
REQ-021: Table write occurs at the clock edge when tbl_we=1 and busy=0; a write while busy is ignored.
REQ-022: start is accepted in IDLE or DONE only; in any busy state it is ignored.
REQ-023: Accepted start clears pass_cnt, err_cnt, fail_vld, fail_idx and done, latches vec_cnt and stop_on_err, and sets idx=0.
REQ-024: Accepted start with vec_cnt=0 goes directly to DONE next cycle, issuing nothing.
REQ-025: Accepted start with vec_cnt>0 enters ISSUE next cycle.
REQ-026: vec_cnt greater than DEPTH is clamped to DEPTH.
REQ-027: In ISSUE (cycle N), inst_out = table[idx].inst and inst_vld=1.
REQ-028: inst_out holds table[idx].inst through cycles N+1..N+LATENCY with inst_vld=0.
REQ-029: ISSUE -> CHECK when LATENCY=1; otherwise ISSUE -> WAIT for LATENCY-1 cycles -> CHECK, so CHECK occurs at cycle N+LATENCY.
REQ-030: In CHECK, mismatch = |((uop_in ^ table[idx].exp) & table[idx].mask); a zero mask always passes.
REQ-031: At the end of CHECK, err_cnt increments on mismatch, otherwise pass_cnt increments.
REQ-032: On the first mismatch of a run, fail_vld <= 1 and fail_idx <= idx; later mismatches do not alter them.
REQ-033: After CHECK: if (mismatch and latched stop_on_err) or idx = latched count-1, go to DONE; else increment idx and go to ISSUE.
REQ-034: Back-to-back entries have no idle cycle between CHECK and the next ISSUE (entry period LATENCY+1 cycles).
REQ-035: In IDLE and DONE, inst_out = IDLE_INST and inst_vld=0.
REQ-036: done=1 exactly while in DONE; counters and fail fields hold in DONE until the next accepted start.
REQ-037: pass_cnt + err_cnt equals the number of CHECK cycles completed in the run; counters never wrap (max DEPTH).

Reset
REQ-038: With rst=0 at a rising edge, the next state is IDLE, regardless of current state (including mid-run).
REQ-039: Reset values: inst_out=IDLE_INST, inst_vld=0, busy=0, done=0, pass_cnt=0, err_cnt=0, fail_vld=0, fail_idx=0, idx=0.
REQ-040: Table contents are not reset and survive rst; start and tbl_we are ignored while rst=0.

Verification
REQ-041: Load entry 0 = {16'h481F, mask bit18, exp bit18=1}; uop_in bit18=1 at N+1; start, vec_cnt=1 -> inst_vld pulse, then done=1, pass_cnt=1, err_cnt=0, fail_vld=0.
REQ-042: Load 4 entries (0x0000, 0x481F, 0xA81F, 0xD710); entry 2 mismatches; stop_on_err=0 -> pass_cnt=3, err_cnt=1, fail_idx=2, entries issued every 2 cycles.
REQ-043: Same as REQ-042 with stop_on_err=1 -> done after entry 2; pass_cnt=2, err_cnt=1; entry 3 is never issued.
REQ-044: LATENCY=3, single entry -> inst_out held 4 cycles, inst_vld high only in the first, uop_in sampled only at N+3.
REQ-045: start with vec_cnt=0 -> done next cycle, no inst_vld; second start mid-run and tbl_we mid-run are ignored (table readback unchanged).
REQ-046: rst=0 during WAIT -> next cycle IDLE, inst_out=16'h0800, counters 0; rerun reproduces original results.
